count_sequencer: RTL
====================

COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 The block SHALL have parameter LEN_W, default 16: width of the command run length.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: number of buffered commands, a power of two and at least 2.
REQ-003 The block SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port cmd_valid  input  1  command offered.
REQ-006 The block SHALL have port cmd_ready  output  1  command can be accepted.
REQ-007 The block SHALL have port cmd_dir  input  1  1 = count up, 0 = count down.
REQ-008 The block SHALL have port cmd_len  input  LEN_W  number of counter steps.
REQ-009 The block SHALL have port cnt_enable  output  1  drives the counter's enable.
REQ-010 The block SHALL have port cnt_upDown  output  1  drives the counter's upDown.
REQ-011 The block SHALL have port busy  output  1  high while not in IDLE or while the FIFO is non-empty.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse when a command completes.

Function
REQ-013 A command SHALL be accepted (pushed to FIFO) in a cycle where cmd_valid && cmd_ready; cmd_ready = !fifo_full, combinational from the FIFO count only.
REQ-014 The FSM SHALL have states IDLE, RUN, DONE.
REQ-015 IDLE with FIFO non-empty SHALL pop the head command, load remaining = cmd_len, latch dir, and go to RUN if cmd_len != 0, else to DONE.
REQ-016 In RUN, cnt_enable SHALL be 1 and cnt_upDown SHALL equal the latched dir every cycle; remaining decrements each cycle; on the cycle remaining == 1 the next state SHALL be DONE.
REQ-017 In DONE, cnt_enable SHALL be 0, done SHALL be 1 for exactly that cycle, and the next state SHALL be IDLE.
REQ-018 Latency: a command accepted in cycle t SHALL produce cnt_enable high from cycle t+2 for exactly cmd_len consecutive cycles, with done at t+2+cmd_len.
REQ-019 cmd_len = 0 SHALL give zero enable cycles and done at t+2.
REQ-020 Back-to-back commands SHALL be separated by exactly two cnt_enable-low cycles (DONE, IDLE).
REQ-021 Outside RUN, cnt_enable SHALL be 0 and cnt_upDown SHALL hold its last value.
REQ-022 A simultaneous push and pop SHALL be legal when the FIFO is non-full; the FIFO count SHALL be unchanged in that case.
REQ-023 Max cmd_len (2^LEN_W-1) SHALL run to completion without wrap of remaining.

Reset
REQ-024 Reset SHALL set state IDLE, FIFO empty, remaining 0, cnt_enable 0, cnt_upDown 1, done 0, busy 0; cmd_ready SHALL be 1 in the first cycle after reset.
REQ-025 Reset mid-RUN SHALL discard the active and all queued commands with no done pulse.

Configuration
REQ-026 With macro COUNT_SEQ_ABORT_EN defined, the block SHALL have input port abort (1 bit); without it, the port and its logic SHALL be absent.
REQ-027 abort high SHALL force IDLE, flush the FIFO, and drive cnt_enable 0 from the next cycle, with no done pulse.
REQ-028 abort SHALL take priority over acceptance: cmd_ready SHALL be 0 while abort is high.

Structure
REQ-029 Package count_seq_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the command struct {dir, len}.
REQ-030 The FIFO SHALL be sub-module count_seq_fifo (synchronous, parameterised depth and width, with full, empty and flush).

Verification
REQ-031 The bench SHALL cover a single command: dir=1, len=5 accepted at t -> cnt_enable 1 at t+2..t+6, cnt_upDown 1, done at t+7; with the counter attached and starting at 0, count = 5.
REQ-032 The bench SHALL cover zero length: len=0 -> no enable cycles, done at t+2.
REQ-033 The bench SHALL cover a full FIFO: 5 commands offered with len=3 on consecutive cycles -> cmd_ready drops after FIFO fill, all commands execute in order, and the counter result equals the net up minus down steps.
REQ-034 The bench SHALL cover direction switching: {up,4} then {down,6} -> the counter goes 0 to 4, wraps to 0xFFFFFFFE, with two idle cycles between runs.
REQ-035 The bench SHALL cover reset mid-run: reset at step 3 of len=10 -> cnt_enable 0 next cycle, busy 0, no done pulse.
REQ-036 The bench SHALL cover abort (COUNT_SEQ_ABORT_EN): abort during RUN with 2 commands queued -> FIFO empty, cmd_ready 0 during abort, no done pulse.

Source files
------------

// File: rtl/count_seq_pkg.sv
// Shared types for the count sequencer: FSM state encoding and the
// buffered command record.
package count_seq_pkg;

  // Widest run length a command record can carry; LEN_W must not exceed it.
  localparam int CMD_LEN_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic                     dir;
    logic [CMD_LEN_MAX_W-1:0] len;
  } cmd_t;

endpackage

// File: rtl/count_seq_fifo.sv
// Synchronous command FIFO. DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally. Push when full and pop when empty are ignored;
// flush empties the FIFO and wins over push and pop in the same cycle.
module count_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/count_sequencer.sv
// Count sequencer: buffers {dir, len} commands and replays each one as a
// run of len enable cycles to an external up/down counter, followed by a
// one-cycle done pulse.
// Optional feature: define COUNT_SEQ_ABORT_EN to add the abort input, which
// drops the active command and flushes the queue without a done pulse.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting; pops the head command as soon as the FIFO has one
//   RUN   | counter enabled, one step per cycle until remaining hits 1
//   DONE  | command finished; done pulses for this single cycle
module count_sequencer #(
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
`ifdef COUNT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cnt_enable,
  output logic             cnt_upDown,
  output logic             busy,
  output logic             done
);

  import count_seq_pkg::*;

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic [LEN_W-1:0] r_remaining;
  logic             r_dir;
  logic             r_updown_hold;
  logic             w_abort;
  logic             w_push;
  logic             w_pop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [LEN_W:0]   w_fifo_q;
  cmd_t             w_head;

`ifdef COUNT_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Ready depends only on FIFO occupancy (and abort), never on cmd_valid.
  assign cmd_ready = !w_fifo_full && !w_abort;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_head    = {w_fifo_q[LEN_W], CMD_LEN_MAX_W'(w_fifo_q[LEN_W-1:0])};

  assign busy       = (r_state != IDLE) || !w_fifo_empty;
  // Direction is shown live during a run and frozen at the last run's value otherwise.
  assign cnt_upDown = (r_state == RUN) ? r_dir : r_updown_hold;

  count_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LEN_W + 1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_abort),
    .i_push  (w_push),
    .i_data  ({cmd_dir, cmd_len}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_q),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state, pop request and counter/done outputs.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    cnt_enable   = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_next_state = (w_head.len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        cnt_enable = 1'b1;
        if (r_remaining == LEN_W'(1)) w_next_state = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    if (w_abort) begin
      w_next_state = IDLE;
      w_pop        = 1'b0;
      done         = 1'b0;
    end
  end

  // Run-length counter and direction latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_remaining   <= '0;
      r_dir         <= 1'b1;
      r_updown_hold <= 1'b1;
    end else if (w_abort) begin
      r_remaining <= '0;
    end else begin
      if (w_pop) begin
        r_remaining <= w_head.len[LEN_W-1:0];
        r_dir       <= w_head.dir;
      end else if (r_state == RUN) begin
        r_remaining <= r_remaining - LEN_W'(1);
      end
      if (r_state == RUN) r_updown_hold <= r_dir;
    end
  end

endmodule
